// File: rtl/bitcoin_mem_responder.sv
// Memory-side responder for the bitcoin_hash miner: word-addressed SRAM model
// with registered reads, a host preload/readback port, result-window write
// tracking and sticky protocol-error flags.
module bitcoin_mem_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned NUM_NONCES = 16,
    parameter logic [31:0] POISON     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        host_we,
    input  logic        host_re,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    input  logic [15:0] out_base,
    input  logic        arm,
    output logic [1:0]  state_o,
    output logic [7:0]  wr_count,
    output logic        results_ready,
    output logic        err_addr,
    output logic        err_wr
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIN     = 8 * NUM_NONCES;
    localparam int unsigned OW      = $clog2(WIN);
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);
    localparam logic [16:0] WIN17   = 17'(WIN);
    localparam logic [7:0]  WIN8    = 8'(WIN);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_RUN      = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    logic [31:0]    mem_q [DEPTH];

    state_t         state_q, state_d;
    logic [31:0]    mem_read_data_q, mem_read_data_d;
    logic [31:0]    host_rdata_q, host_rdata_d;
    logic           host_rvalid_q, host_rvalid_d;
    logic [7:0]     wr_count_q, wr_count_d;
    logic           results_ready_q, results_ready_d;
    logic           err_addr_q, err_addr_d;
    logic           err_wr_q, err_wr_d;
    logic [WIN-1:0] bitmap_q, bitmap_d;
    logic [15:0]    base_q, base_d;

    logic [16:0]    maddr17, haddr17, base17, win_end17;
    logic           m_in_range, h_in_range, in_win, host_side;
    logic           miner_commit, host_commit;
    logic [AW-1:0]  m_idx, h_idx;
    logic [OW-1:0]  win_off;
    logic [31:0]    m_rd_word, h_rd_word;

    // Address decode: all window arithmetic is done in 17 bits so it never wraps.
    always_comb begin
        maddr17    = {1'b0, mem_addr};
        haddr17    = {1'b0, host_addr};
        base17     = {1'b0, base_q};
        win_end17  = base17 + WIN17;
        m_in_range = maddr17 < DEPTH17;
        h_in_range = haddr17 < DEPTH17;
        in_win     = (maddr17 >= base17) && (maddr17 < win_end17);
        win_off    = OW'(maddr17 - base17);
        m_idx      = mem_addr[AW-1:0];
        h_idx      = host_addr[AW-1:0];
        m_rd_word  = m_in_range ? mem_q[m_idx] : POISON;
        h_rd_word  = h_in_range ? mem_q[h_idx] : POISON;
        host_side  = state_q != S_RUN;
        miner_commit = reset_n && mem_we && m_in_range && (state_q != S_LOAD);
        host_commit  = reset_n && host_side && host_we && h_in_range;
    end

    // Next-state logic for the run controller, read ports and error flags.
    always_comb begin
        state_d         = state_q;
        mem_read_data_d = m_rd_word;
        host_rdata_d    = host_rdata_q;
        host_rvalid_d   = 1'b0;
        wr_count_d      = wr_count_q;
        results_ready_d = results_ready_q;
        err_addr_d      = err_addr_q;
        err_wr_d        = err_wr_q;
        bitmap_d        = bitmap_q;
        base_d          = base_q;

        if (host_side && !host_we && host_re) begin
            host_rdata_d  = h_rd_word;
            host_rvalid_d = 1'b1;
        end

        case (state_q)
            S_LOAD: begin
                if (mem_we) err_wr_d = 1'b1;
            end
            S_RUN: begin
                // mem_addr is read every cycle, so any out-of-range address is an access
                if (!m_in_range) err_addr_d = 1'b1;
                if (mem_we && m_in_range) begin
                    if (in_win) begin
                        if (!bitmap_q[win_off]) begin
                            bitmap_d[win_off] = 1'b1;
                            wr_count_d        = wr_count_q + 8'd1;
                            if (wr_count_q + 8'd1 == WIN8) begin
                                state_d         = S_COMPLETE;
                                results_ready_d = 1'b1;
                            end
                        end
                    end else begin
                        err_wr_d = 1'b1;
                    end
                end
            end
            S_COMPLETE: begin
                if (mem_we) err_wr_d = 1'b1;
            end
            default: state_d = S_LOAD;
        endcase

        if (arm && host_side) begin
            state_d         = S_RUN;
            base_d          = out_base;
            bitmap_d        = '0;
            wr_count_d      = '0;
            results_ready_d = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_LOAD;
            mem_read_data_q <= '0;
            host_rdata_q    <= '0;
            host_rvalid_q   <= 1'b0;
            wr_count_q      <= '0;
            results_ready_q <= 1'b0;
            err_addr_q      <= 1'b0;
            err_wr_q        <= 1'b0;
            bitmap_q        <= '0;
            base_q          <= '0;
        end else begin
            state_q         <= state_d;
            mem_read_data_q <= mem_read_data_d;
            host_rdata_q    <= host_rdata_d;
            host_rvalid_q   <= host_rvalid_d;
            wr_count_q      <= wr_count_d;
            results_ready_q <= results_ready_d;
            err_addr_q      <= err_addr_d;
            err_wr_q        <= err_wr_d;
            bitmap_q        <= bitmap_d;
            base_q          <= base_d;
        end
    end

    // Array writes (not reset); host write is ordered last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (miner_commit) mem_q[m_idx] <= mem_write_data;
        if (host_commit)  mem_q[h_idx] <= host_wdata;
    end

    assign mem_read_data = mem_read_data_q;
    assign host_rdata    = host_rdata_q;
    assign host_rvalid   = host_rvalid_q;
    assign state_o       = state_q;
    assign wr_count      = wr_count_q;
    assign results_ready = results_ready_q;
    assign err_addr      = err_addr_q;
    assign err_wr        = err_wr_q;

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Self-checking bench for bitcoin_mem_responder: directed scenarios followed
// by randomized traffic, all outputs compared every cycle against a
// behavioural model of the memory, run window and error flags.
module tb_bitcoin_mem_responder;

    localparam int          DEPTH  = 256;
    localparam int          NN     = 16;
    localparam int          WIN    = 8 * NN;
    localparam logic [31:0] POISON = 32'hDEADBEEF;
    localparam int          ST_LOAD = 0, ST_RUN = 1, ST_COMPLETE = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        host_we = 1'b0;
    logic        host_re = 1'b0;
    logic [15:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [15:0] out_base = '0;
    logic        arm = 1'b0;
    logic [1:0]  state_o;
    logic [7:0]  wr_count;
    logic        results_ready;
    logic        err_addr;
    logic        err_wr;

    always #5 clk = ~clk;

    bitcoin_mem_responder #(
        .DEPTH(DEPTH),
        .NUM_NONCES(NN),
        .POISON(POISON)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .host_we(host_we),
        .host_re(host_re),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .out_base(out_base),
        .arm(arm),
        .state_o(state_o),
        .wr_count(wr_count),
        .results_ready(results_ready),
        .err_addr(err_addr),
        .err_wr(err_wr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference model
    int          m_state = ST_LOAD;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_mrd = '0;
    logic [31:0] m_hrd = '0;
    bit          m_hrv = 0, m_rr = 0, m_ea = 0, m_ew = 0;
    int          m_base = 0;
    bit          seen [int];
    bit          mrd_chk = 0;

    task automatic model_step();
        int ma, ha, st;
        logic [31:0] new_mrd;
        bit host_wr;
        ma = int'(mem_addr);
        ha = int'(host_addr);
        st = m_state;
        if (!reset_n) begin
            m_state = ST_LOAD; m_mrd = '0; m_hrd = '0; m_hrv = 0;
            m_rr = 0; m_ea = 0; m_ew = 0; m_base = 0;
            seen.delete();
            return;
        end
        new_mrd = (ma < DEPTH) ? m_mem[ma] : POISON;
        m_hrv = 0;
        host_wr = 0;
        if (st != ST_RUN) begin
            if (host_we) host_wr = (ha < DEPTH);
            else if (host_re) begin
                m_hrd = (ha < DEPTH) ? m_mem[ha] : POISON;
                m_hrv = 1;
            end
        end
        if (st == ST_RUN && ma >= DEPTH) m_ea = 1;
        if (mem_we) begin
            if (st == ST_LOAD) m_ew = 1;
            else if (st == ST_COMPLETE) begin
                if (ma < DEPTH) m_mem[ma] = mem_write_data;
                m_ew = 1;
            end else if (ma < DEPTH) begin
                m_mem[ma] = mem_write_data;
                if (ma >= m_base && ma < m_base + WIN) begin
                    seen[ma] = 1;
                    if (seen.num() == WIN) begin
                        m_state = ST_COMPLETE;
                        m_rr = 1;
                    end
                end else m_ew = 1;
            end
        end
        if (host_wr) m_mem[ha] = host_wdata;
        if (arm && st != ST_RUN) begin
            m_state = ST_RUN;
            m_base = int'(out_base);
            seen.delete();
            m_rr = 0;
        end
        m_mrd = new_mrd;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("state", 32'(state_o), 32'(m_state));
        check("wr_count", 32'(wr_count), 32'(seen.num()));
        check("results_ready", 32'(results_ready), 32'(m_rr));
        check("err_addr", 32'(err_addr), 32'(m_ea));
        check("err_wr", 32'(err_wr), 32'(m_ew));
        check("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
        check("host_rdata", host_rdata, m_hrd);
        if (mrd_chk) check("mem_read_data", mem_read_data, m_mrd);
    endtask

    task automatic idle();
        mem_we = 0; host_we = 0; host_re = 0; arm = 0;
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        host_we = 1; host_addr = 16'(a); host_wdata = d;
        cycle();
        idle();
    endtask

    task automatic host_read(input int a);
        host_re = 1; host_addr = 16'(a);
        cycle();
        idle();
    endtask

    task automatic miner_write(input int a, input logic [31:0] d);
        mem_we = 1; mem_addr = 16'(a); mem_write_data = d;
        cycle();
        idle();
    endtask

    task automatic miner_read(input int a);
        mem_addr = 16'(a);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        logic [31:0] v80;

        // Reset and preload: the whole array gets a known value
        idle();
        reset_n = 0;
        cycle();
        cycle();
        reset_n = 1;
        for (int i = 0; i < DEPTH; i++) host_write(i, 32'h1000 + i);
        mrd_chk = 1;
        cycle();
        host_read(5);
        check("t1_host_rdata", host_rdata, 32'h1005);
        check("t1_host_rvalid", 32'(host_rvalid), 32'd1);
        miner_read(3);
        check("t1_mem_read_data", mem_read_data, 32'h1003);

        // Full clean run over window 0x80..0xFF in shuffled order
        out_base = 16'h0080; arm = 1;
        cycle();
        idle();
        for (int a = 16'h80; a < 16'h100; a++) order.push_back(a);
        order.shuffle();
        foreach (order[k]) miner_write(order[k], $urandom);
        check("t2_state", 32'(state_o), 32'd2);
        check("t2_results_ready", 32'(results_ready), 32'd1);
        check("t2_wr_count", 32'(wr_count), 32'd128);
        check("t2_err_wr", 32'(err_wr), 32'd0);
        for (int a = 16'h80; a < 16'h100; a++) host_read(a);
        v80 = m_mem[16'h80];

        // Duplicate and out-of-window writes, out-of-range access
        out_base = 16'h0080; arm = 1;
        cycle();
        idle();
        miner_write(16'h85, 32'hA);
        miner_write(16'h85, 32'hB);
        check("t3_wr_count", 32'(wr_count), 32'd1);
        miner_read(16'h85);
        check("t3_dup_data", mem_read_data, 32'hB);
        miner_write(16'h10, 32'h77);
        check("t3_err_wr", 32'(err_wr), 32'd1);
        miner_read(16'h100);
        check("t4_poison", mem_read_data, POISON);
        check("t4_err_addr", 32'(err_addr), 32'd1);
        miner_write(16'h100, 32'h99);
        check("t4_wr_count", 32'(wr_count), 32'd1);

        // Reset mid-run keeps array contents
        for (int a = 16'h86; a < 16'h86 + 39; a++) miner_write(a, $urandom);
        check("t6_wr_count", 32'(wr_count), 32'd40);
        reset_n = 0;
        cycle();
        reset_n = 1;
        check("t6_state", 32'(state_o), 32'd0);
        check("t6_flags", {30'd0, err_addr, err_wr}, 32'd0);
        host_read(16'h80);
        check("t6_retained", host_rdata, v80);

        // Miner writes in LOAD are dropped and flagged
        miner_write(16'h20, 32'h55);
        check("t5_err_wr", 32'(err_wr), 32'd1);
        host_read(16'h20);
        check("t5_unchanged", host_rdata, 32'h1020);
        mem_we = 1; mem_addr = 16'h21; mem_write_data = 32'h66;
        out_base = 16'h0040; arm = 1;
        cycle();
        idle();
        check("t5_state", 32'(state_o), 32'd1);
        miner_read(16'h21);
        check("t5_dropped", mem_read_data, 32'h1021);

        // Randomized traffic
        for (int n = 0; n < 5000; n++) begin
            int r;
            reset_n = ($urandom_range(0, 999) != 0);
            r = $urandom_range(0, 99);
            if (r < 70)      mem_addr = 16'(m_base + $urandom_range(0, WIN - 1));
            else if (r < 78) mem_addr = 16'($urandom_range(DEPTH, 16'h1FF));
            else if (r < 80) mem_addr = 16'hFFFF;
            else             mem_addr = 16'($urandom_range(0, DEPTH - 1));
            mem_we = ($urandom_range(0, 99) < 55);
            mem_write_data = $urandom;
            host_we = ($urandom_range(0, 99) < 10);
            host_re = ($urandom_range(0, 99) < 25);
            host_addr = 16'(($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 16'hFFFF)
                                                          : $urandom_range(0, DEPTH - 1));
            host_wdata = $urandom;
            arm = ($urandom_range(0, 99) < 4);
            r = $urandom_range(0, 9);
            out_base = (r < 3) ? 16'h0000 : (r < 6) ? 16'h0080 : (r < 8) ? 16'h0040
                                                    : 16'($urandom_range(0, 16'h1FF));
            cycle();
        end
        idle();
        reset_n = 1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
